operand_fetch_ctrl: RTL and testbench

Initiator-side controller for the 8-entry, 16-bit, two-read/one-write register file of the simple architecture. Accepts one 16-bit instruction at a time, drives register-file read addresses and captures both operands, then hands them to the ALU. It writes the ALU result back to the destination register. Sits between the instruction source and the ALU, owning every register-file access.

---
 rtl/operand_fetch_ctrl_if.sv | 42 ++++
 rtl/operand_fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_operand_fetch_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_ctrl_if.sv
// Handshake and bus bundle between the operand fetch controller and its
// neighbours: instruction source, register file, ALU and writeback.
interface operand_fetch_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;
  logic              rf_read;
  logic [ADDR_W-1:0] rf_addr1;
  logic [ADDR_W-1:0] rf_addr2;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              op_valid;
  logic              op_ready;
  logic [3:0]        op_code;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              err;
  logic [15:0]       retired;

  // Controller side: owns every register-file access
  modport master (
    input  instr_valid, instr, rf_data1, rf_data2, op_ready, wb_valid, wb_data,
    output instr_ready, rf_read, rf_addr1, rf_addr2, rf_write, rf_waddr,
           rf_wdata, op_valid, op_code, op_a, op_b, wb_ready, err, retired
  );

  // Environment side: instruction source, register file and ALU
  modport slave (
    output instr_valid, instr, rf_data1, rf_data2, op_ready, wb_valid, wb_data,
    input  instr_ready, rf_read, rf_addr1, rf_addr2, rf_write, rf_waddr,
           rf_wdata, op_valid, op_code, op_a, op_b, wb_ready, err, retired
  );
endinterface

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch controller: accepts one instruction at a time, reads both
// source registers, issues them to the ALU and writes the result back to rd.
// Every output comes straight from a register.
module operand_fetch_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 8
) (
  input logic clk,
  input logic reset_n,
  operand_fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    ISSUE,
    WAIT_WB,
    WRITE
  } state_t;

  localparam logic [ADDR_W-1:0] LP_NUM_REGS = ADDR_W'(NUM_REGS);

  state_t            r_state;
  logic              r_instr_ready;
  logic              r_rf_read;
  logic [ADDR_W-1:0] r_rf_addr1;
  logic [ADDR_W-1:0] r_rf_addr2;
  logic              r_rf_write;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_op_valid;
  logic [3:0]        r_op_code;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic              r_wb_ready;
  logic              r_err;
  logic [15:0]       r_retired;
  logic [ADDR_W-1:0] r_rd;

  logic [3:0]        w_opcode;
  logic [ADDR_W-1:0] w_rd;
  logic [ADDR_W-1:0] w_rs1;
  logic [ADDR_W-1:0] w_rs2;
  logic              w_accept;
  logic              w_illegal;

  assign w_opcode  = bus.instr[15:12];
  assign w_rd      = bus.instr[11:8];
  assign w_rs1     = bus.instr[7:4];
  assign w_rs2     = bus.instr[3:0];
  assign w_accept  = bus.instr_valid && r_instr_ready;
  assign w_illegal = (w_rd >= LP_NUM_REGS) || (w_rs1 >= LP_NUM_REGS) ||
                     (w_rs2 >= LP_NUM_REGS);

  // Sequencer: one instruction in flight, outputs updated alongside the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_instr_ready <= 1'b0;
      r_rf_read     <= 1'b0;
      r_rf_addr1    <= '0;
      r_rf_addr2    <= '0;
      r_rf_write    <= 1'b0;
      r_rf_waddr    <= '0;
      r_rf_wdata    <= '0;
      r_op_valid    <= 1'b0;
      r_op_code     <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_wb_ready    <= 1'b0;
      r_err         <= 1'b0;
      r_retired     <= '0;
      r_rd          <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_instr_ready <= 1'b1;
          if (w_accept) begin
            if (w_illegal) begin
              r_err <= 1'b1;
            end else if (w_opcode != 4'h0) begin
              r_instr_ready <= 1'b0;
              r_rd          <= w_rd;
              r_op_code     <= w_opcode;
              r_rf_addr1    <= w_rs1;
              r_rf_addr2    <= w_rs2;
              r_rf_read     <= 1'b1;
              r_state       <= READ;
            end
          end
        end
        READ: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_op_a     <= bus.rf_data1;
          r_op_b     <= bus.rf_data2;
          r_rf_read  <= 1'b0;
          r_op_valid <= 1'b1;
          r_state    <= ISSUE;
        end
        ISSUE: begin
          if (bus.op_ready) begin
            r_op_valid <= 1'b0;
            r_wb_ready <= 1'b1;
            r_state    <= WAIT_WB;
          end
        end
        WAIT_WB: begin
          if (bus.wb_valid) begin
            r_wb_ready <= 1'b0;
            r_rf_wdata <= bus.wb_data;
            r_rf_waddr <= r_rd;
            r_rf_write <= 1'b1;
            r_state    <= WRITE;
          end
        end
        WRITE: begin
          r_rf_write    <= 1'b0;
          r_retired     <= r_retired + 16'd1;
          r_instr_ready <= 1'b1;
          r_state       <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = r_instr_ready;
  assign bus.rf_read     = r_rf_read;
  assign bus.rf_addr1    = r_rf_addr1;
  assign bus.rf_addr2    = r_rf_addr2;
  assign bus.rf_write    = r_rf_write;
  assign bus.rf_waddr    = r_rf_waddr;
  assign bus.rf_wdata    = r_rf_wdata;
  assign bus.op_valid    = r_op_valid;
  assign bus.op_code     = r_op_code;
  assign bus.op_a        = r_op_a;
  assign bus.op_b        = r_op_b;
  assign bus.wb_ready    = r_wb_ready;
  assign bus.err         = r_err;
  assign bus.retired     = r_retired;

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Directed bench for operand_fetch_ctrl with a small register-file model.
module tb_operand_fetch_ctrl;

  logic clk;
  logic reset_n;
  int   testsRun  = 0;
  int   failCount = 0;
  int   readCount = 0;
  int   writeCount = 0;
  int   overlapCount = 0;
  int   readSnap;
  int   writeSnap;

  logic [15:0] regs [8] = '{16'h0000, 16'h1234, 16'h00FF, 16'h0000,
                            16'h4444, 16'h5555, 16'h0000, 16'h0000};

  operand_fetch_ctrl_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  operand_fetch_ctrl #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(8)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.master)
  );

  assign bus.rf_data1 = regs[bus.rf_addr1[2:0]];
  assign bus.rf_data2 = regs[bus.rf_addr2[2:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file write port and activity counters for the cycle just ending
  always @(posedge clk) begin
    if (bus.rf_write) regs[bus.rf_waddr[2:0]] <= bus.rf_wdata;
    if (bus.rf_read) readCount++;
    if (bus.rf_write) writeCount++;
    if (bus.rf_read && bus.rf_write) overlapCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".instrReady"}, 32'(bus.instr_ready), 32'd0);
    checkOutput({tag, ".ctrl"}, {27'd0, bus.rf_read, bus.rf_write, bus.op_valid,
                bus.wb_ready, bus.err}, 32'd0);
    checkOutput({tag, ".addrs"}, {20'd0, bus.rf_addr1, bus.rf_addr2, bus.rf_waddr}, 32'd0);
    checkOutput({tag, ".opAB"}, {bus.op_a, bus.op_b}, 32'd0);
    checkOutput({tag, ".opCodeWdata"}, {12'd0, bus.op_code, bus.rf_wdata}, 32'd0);
    checkOutput({tag, ".retired"}, 32'(bus.retired), 32'd0);
  endtask

  task automatic applyStimulus(input logic [15:0] ins);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  // Drives an already-accepted instruction through the ALU and writeback
  task automatic completeInstr(input string tag, input logic [3:0] rd,
                               input logic [15:0] result);
    bus.op_ready = 1'b1;
    for (int n = 0; n < 10 && !bus.op_valid; n++) @(negedge clk);
    checkOutput({tag, ".opValid"}, 32'(bus.op_valid), 32'd1);
    @(negedge clk);
    bus.op_ready = 1'b0;
    for (int n = 0; n < 10 && !bus.wb_ready; n++) @(negedge clk);
    checkOutput({tag, ".wbReady"}, 32'(bus.wb_ready), 32'd1);
    bus.wb_valid = 1'b1;
    bus.wb_data  = result;
    @(negedge clk);
    bus.wb_valid = 1'b0;
    checkOutput({tag, ".rfWrite"}, 32'(bus.rf_write), 32'd1);
    checkOutput({tag, ".waddrWdata"}, {12'd0, bus.rf_waddr, bus.rf_wdata}, {12'd0, rd, result});
    @(negedge clk);
    checkOutput({tag, ".ready"}, {30'd0, bus.instr_ready, bus.rf_write}, 32'd2);
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.op_ready    = 1'b0;
    bus.wb_valid    = 1'b0;
    bus.wb_data     = '0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterReset", 32'(bus.instr_ready), 32'd1);

    // Basic instruction 0x3312, cycle by cycle
    bus.op_ready = 1'b1;
    applyStimulus(16'h3312);
    checkOutput("t1.c1", {bus.instr_ready, bus.rf_read, bus.rf_addr1, bus.rf_addr2}, 32'h00000112);
    @(negedge clk);
    checkOutput("t1.c2", {bus.rf_read, bus.rf_addr1, bus.rf_addr2, bus.op_valid}, 32'h00000224);
    @(negedge clk);
    checkOutput("t1.c3", {31'd0, bus.rf_read}, 32'd0);
    checkOutput("t1.opValid", {28'd0, bus.op_code}, 32'd3 | 32'(bus.op_valid) << 8 ^ 32'h100);
    checkOutput("t1.opAB", {bus.op_a, bus.op_b}, 32'h123400FF);
    checkOutput("t1.opValidHigh", 32'(bus.op_valid), 32'd1);
    @(negedge clk);
    bus.op_ready = 1'b0;
    checkOutput("t1.c4", {30'd0, bus.wb_ready, bus.op_valid}, 32'd2);
    bus.wb_valid = 1'b1;
    bus.wb_data  = 16'hABCD;
    @(negedge clk);
    bus.wb_valid = 1'b0;
    checkOutput("t1.c5", {11'd0, bus.rf_write, bus.rf_waddr, bus.rf_wdata}, 32'h0013ABCD);
    @(negedge clk);
    checkOutput("t1.c6", {30'd0, bus.instr_ready, bus.rf_write}, 32'd2);
    checkOutput("t1.retired", 32'(bus.retired), 32'd1);
    checkOutput("t1.reg3", 32'(regs[3]), 32'h0000ABCD);

    // Back-to-back illegal instructions
    readSnap  = readCount;
    writeSnap = writeCount;
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h2980;
    @(negedge clk);
    checkOutput("t2.err1", {30'd0, bus.err, bus.instr_ready}, 32'd3);
    bus.instr = 16'h1A00;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    checkOutput("t2.err2", {30'd0, bus.err, bus.instr_ready}, 32'd3);
    @(negedge clk);
    checkOutput("t2.errEnd", {30'd0, bus.err, bus.instr_ready}, 32'd1);
    checkOutput("t2.noAccess", 32'(readCount - readSnap + writeCount - writeSnap), 32'd0);
    checkOutput("t2.retired", 32'(bus.retired), 32'd1);

    // NOP then an immediately following instruction
    readSnap = readCount;
    applyStimulus(16'h0123);
    checkOutput("t3.nop", {29'd0, bus.err, bus.rf_read, bus.instr_ready}, 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h4712;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    checkOutput("t3.nextAccepted", {30'd0, bus.rf_read, bus.instr_ready}, 32'd2);
    checkOutput("t3.nopNoRead", 32'(readCount - readSnap), 32'd0);
    completeInstr("t3", 4'd7, 16'h1111);
    checkOutput("t3.retired", 32'(bus.retired), 32'd2);

    // ALU stalls on op_ready, then late writeback
    writeSnap = writeCount;
    applyStimulus(16'h6745);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t4.stall%0d", i),
                  {11'd0, bus.op_valid, bus.op_code, bus.rf_write, 15'd0}, 32'h00168000 ^ 32'h8000);
      checkOutput($sformatf("t4.ops%0d", i), {bus.op_a, bus.op_b}, 32'h44445555);
      if (i == 4) bus.op_ready = 1'b1;
      @(negedge clk);
    end
    bus.op_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t4.wbWait%0d", i),
                  {29'd0, bus.wb_ready, bus.op_valid, bus.rf_write}, 32'd4);
      if (i == 2) begin
        bus.wb_valid = 1'b1;
        bus.wb_data  = 16'h7777;
      end
      @(negedge clk);
    end
    bus.wb_valid = 1'b0;
    checkOutput("t4.write", {11'd0, bus.rf_write, bus.rf_waddr, bus.rf_wdata}, 32'h00177777);
    @(negedge clk);
    checkOutput("t4.oneWrite", 32'(writeCount - writeSnap), 32'd1);
    checkOutput("t4.retired", 32'(bus.retired), 32'd3);

    // Reset during WAIT_WB aborts the pending write
    writeSnap = writeCount;
    bus.op_ready = 1'b1;
    applyStimulus(16'h7112);
    repeat (3) @(negedge clk);
    bus.op_ready = 1'b0;
    checkOutput("t5.inWaitWb", 32'(bus.wb_ready), 32'd1);
    bus.wb_valid = 1'b1;
    bus.wb_data  = 16'hDEAD;
    reset_n      = 1'b0;
    #1;
    checkResetState("t5.reset");
    repeat (2) @(negedge clk);
    bus.wb_valid = 1'b0;
    reset_n      = 1'b1;
    @(negedge clk);
    checkOutput("t5.ready", 32'(bus.instr_ready), 32'd1);
    checkOutput("t5.noWrite", 32'(writeCount - writeSnap), 32'd0);
    checkOutput("t5.reg1", 32'(regs[1]), 32'h00001234);
    applyStimulus(16'h8345);
    completeInstr("t5.next", 4'd3, 16'hBEEF);
    checkOutput("t5.reg3", 32'(regs[3]), 32'h0000BEEF);
    checkOutput("t5.retired", 32'(bus.retired), 32'd1);

    // Retired counter wrap
    force dut.r_retired = 16'hFFFF;
    @(negedge clk);
    release dut.r_retired;
    @(negedge clk);
    checkOutput("t6.preset", 32'(bus.retired), 32'h0000FFFF);
    applyStimulus(16'h9012);
    completeInstr("t6", 4'd0, 16'h0001);
    checkOutput("t6.wrap", 32'(bus.retired), 32'd0);

    checkOutput("noReadWriteOverlap", 32'(overlapCount), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
